// File: rtl/xor_hash_arbiter.sv
// xor_hash_arbiter
//   Round-robin arbiter/sequencer sharing one external combinational xor_hash
//   (DATA_W -> HASH_W) among N_REQ requesters. One block is accepted per grant,
//   held in hash_in while the hash settles, and the digest is returned with the
//   requester index on a valid/ready response channel.
//
//   Ports:
//     clk, rst_n            clock (rising edge), async active-low reset
//     req_valid/req_ready   per-requester handshake; req_ready one-hot or zero
//     req_data              requester i block at [i*DATA_W +: DATA_W]
//     hash_in / hash_out    registered drive to / combinational return from xor_hash
//     rsp_valid/rsp_ready   digest response handshake
//     rsp_hash, rsp_id      digest and index of the requester that produced it
//     stat_done             (XOR_HASH_ARB_STATS_EN only) saturating count of
//                           completed responses
//
//   Optional feature macro: XOR_HASH_ARB_STATS_EN
module xor_hash_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 512,
  parameter int HASH_W = 8,
  parameter int ID_W   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [DATA_W-1:0]       hash_in,
  input  logic [HASH_W-1:0]       hash_out,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [HASH_W-1:0]       rsp_hash,
`ifdef XOR_HASH_ARB_STATS_EN
  output logic [15:0]             stat_done,
`endif
  output logic [ID_W-1:0]         rsp_id
);

  typedef enum logic [1:0] {IDLE, HASH, RESP} state_t;

  state_t          state, state_nx;
  logic [ID_W-1:0] rr_ptr, grant_id, gnt;
  logic            found, take;
  int              j;

  // First valid requester at or after rr_ptr. The wrap is done by subtraction
  // so non-power-of-2 N_REQ works.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    j     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && req_valid[j]) begin
        found = 1'b1;
        gnt   = ID_W'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = '0;
    take      = 1'b0;
    case (state)
      IDLE: if (found) begin
        req_ready[gnt] = 1'b1;
        take           = 1'b1;
        state_nx       = HASH;
      end
      HASH:    state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // hash_in is only reloaded on a grant, so it keeps the last block after RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      grant_id  <= '0;
      hash_in   <= '0;
      rsp_valid <= 1'b0;
      rsp_hash  <= '0;
      rsp_id    <= '0;
    end else begin
      if (take) begin
        hash_in  <= req_data[int'(gnt)*DATA_W +: DATA_W];
        grant_id <= gnt;
      end
      if (state == HASH) begin
        rsp_hash  <= hash_out;
        rsp_id    <= grant_id;
        rsp_valid <= 1'b1;
      end
      if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        rr_ptr    <= (grant_id == ID_W'(N_REQ-1)) ? '0 : grant_id + 1'b1;
      end
    end
  end

`ifdef XOR_HASH_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stat_done <= '0;
    else if (rsp_valid && rsp_ready && stat_done != 16'hFFFF)
      stat_done <= stat_done + 16'd1;
  end
`endif

endmodule

// File: tb/tb_xor_hash_arbiter.sv
// tb_xor_hash_arbiter
//   Bench for xor_hash_arbiter with a byte-fold xor_hash between hash_in and
//   hash_out. A transaction-level model predicts every output each cycle; a
//   set of directed cases pins literal digests, ids, ordering and timing.
module tb_xor_hash_arbiter;
  localparam int N  = 4;
  localparam int DW = 512;
  localparam int HW = 8;
  localparam int IW = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_ready;
  logic [N-1:0][DW-1:0] blk;
  logic [N*DW-1:0]      req_data;
  logic [DW-1:0]        hash_in;
  logic [HW-1:0]        hash_out;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [HW-1:0]        rsp_hash;
  logic [IW-1:0]        rsp_id;
`ifdef XOR_HASH_ARB_STATS_EN
  logic [15:0]          stat_done;
`endif

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;
  assign req_data = blk;

  // stand-in for the external xor_hash: XOR of all 64 bytes
  always_comb begin
    hash_out = '0;
    for (int b = 0; b < DW/8; b++) hash_out = hash_out ^ hash_in[b*8 +: 8];
  end

  xor_hash_arbiter #(.N_REQ(N), .DATA_W(DW), .HASH_W(HW), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .hash_in(hash_in), .hash_out(hash_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hash(rsp_hash),
`ifdef XOR_HASH_ARB_STATS_EN
    .stat_done(stat_done),
`endif
    .rsp_id(rsp_id)
  );

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // golden digest by halving folds (independent of the byte loop above)
  function automatic logic [7:0] fold(input logic [DW-1:0] d);
    logic [255:0] a; logic [127:0] b; logic [63:0] c; logic [31:0] e; logic [15:0] f;
    a = d[511:256] ^ d[255:0];
    b = a[255:128] ^ a[127:0];
    c = b[127:64]  ^ b[63:0];
    e = c[63:32]   ^ c[31:0];
    f = e[31:16]   ^ e[15:0];
    return f[15:8] ^ f[7:0];
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Model: m_age counts edges since the block was accepted (0 = free,
  // 1 = digest due next edge, 2 = response outstanding).
  int           m_ptr, m_age, m_gid, cyc;
  logic [DW-1:0] m_hin;
  logic [HW-1:0] m_hash;
  int           m_id;
  int           done_ids[$];
  int           done_cyc[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr <= 0; m_age <= 0; m_gid <= 0; m_hin <= '0; m_hash <= '0; m_id <= 0;
    end else begin
      cyc <= cyc + 1;
      if (m_age == 0) begin
        if (pick(req_valid, m_ptr) >= 0) begin
          m_hin <= blk[pick(req_valid, m_ptr)];
          m_gid <= pick(req_valid, m_ptr);
          m_age <= 1;
        end
      end else if (m_age == 1) begin
        m_hash <= fold(m_hin);
        m_id   <= m_gid;
        m_age  <= 2;
      end else if (rsp_ready) begin
        m_age <= 0;
        m_ptr <= (m_gid + 1) % N;
        done_ids.push_back(m_gid);
        done_cyc.push_back(cyc);
      end
    end
  end

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    r = '0;
    if (m_age == 0 && pick(req_valid, m_ptr) >= 0) r[pick(req_valid, m_ptr)] = 1'b1;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      chk("req_ready", DW'(req_ready), DW'(exp_ready()));
      chk("rsp_valid", DW'(rsp_valid), DW'(m_age == 2));
      chk("rsp_hash",  DW'(rsp_hash),  DW'(m_hash));
      chk("rsp_id",    DW'(rsp_id),    DW'(m_id));
      chk("hash_in",   hash_in,        m_hin);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    cyc = 0;
    rst_n = 1'b1; req_valid = '0; rsp_ready = 1'b1; blk = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", DW'(req_ready), '0);
    chk("rst_rsp_valid", DW'(rsp_valid), '0);
    chk("rst_hash_in",   hash_in,        '0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // 1: single request from 0
    blk[0] = DW'(1);
    req_valid = 4'b0001;
    #1 chk("t1_grant", DW'(req_ready), DW'(4'b0001));
    tick(1);
    req_valid = '0;
    chk("t1_no_grant_hash", DW'(req_ready), '0);
    tick(1);
    chk("t1_valid", DW'(rsp_valid), DW'(1'b1));
    chk("t1_hash",  DW'(rsp_hash),  DW'(8'h01));
    chk("t1_id",    DW'(rsp_id),    DW'(0));
    tick(1);
    chk("t1_done", DW'(rsp_valid), '0);

    // 2: request 2 only; two bytes of 01 cancel
    blk[2] = {503'b0, 1'b1, 8'h01};
    req_valid = 4'b0100;
    tick(1);
    req_valid = '0;
    tick(1);
    chk("t2_hash", DW'(rsp_hash), DW'(8'h00));
    chk("t2_id",   DW'(rsp_id),   DW'(2));
    tick(1);

    // 4: backpressure with everyone else requesting during RESP
    for (int b = 0; b < 64; b++) blk[3][b*8 +: 8] = 8'(b + 1);
    rsp_ready = 1'b0;
    req_valid = 4'b1000;
    tick(1);
    req_valid = 4'b1111;
    tick(1);
    for (int c = 0; c < 10; c++) begin
      chk("t4_valid", DW'(rsp_valid), DW'(1'b1));
      chk("t4_hash",  DW'(rsp_hash),  DW'(8'h40));
      chk("t4_id",    DW'(rsp_id),    DW'(3));
      chk("t4_ready", DW'(req_ready), '0);
      tick(1);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    tick(1);
    chk("t4_done", DW'(rsp_valid), '0);

    // 5: reset while in HASH
    blk[0] = {16{32'hA5A5_0F0F}};
    req_valid = 4'b0001;
    tick(1);
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("t5_rsp_valid", DW'(rsp_valid), '0);
    chk("t5_rsp_hash",  DW'(rsp_hash),  '0);
    chk("t5_rsp_id",    DW'(rsp_id),    '0);
    chk("t5_hash_in",   hash_in,        '0);
    chk("t5_req_ready", DW'(req_ready), '0);
    tick(2);
    rst_n = 1'b1;
    tick(5);
    chk("t5_no_stray", DW'(rsp_valid), '0);

    // 3: all four continuously valid, starting from pointer 0
    for (int i = 0; i < N; i++)
      for (int w = 0; w < DW/32; w++)
        blk[i][w*32 +: 32] = 32'h9E37_79B9 * 32'(i*16 + w + 1);
    done_ids.delete();
    done_cyc.delete();
    req_valid = 4'b1111;
    n = 0;
    while (done_ids.size() < 5 && n < 40) begin
      tick(1);
      n++;
    end
    req_valid = '0;
    chk("t3_count", DW'(done_ids.size()), DW'(5));
    for (int k = 0; k < 5; k++) begin
      if (k < done_ids.size()) begin
        chk("t3_id_seq", DW'(done_ids[k]), DW'(k % N));
        if (k > 0) chk("t3_spacing", DW'(done_cyc[k] - done_cyc[k-1]), DW'(3));
      end
    end
    tick(3);

`ifdef XOR_HASH_ARB_STATS_EN
    // 6: five completions since the last reset, then saturation
    chk("t6_count", DW'(stat_done), DW'(16'd5));
    force dut.stat_done = 16'hFFFE;
    #1 release dut.stat_done;
    for (int r = 0; r < 2; r++) begin
      req_valid = 4'b0001;
      tick(1);
      req_valid = '0;
      tick(2);
      chk("t6_sat", DW'(stat_done), DW'(16'hFFFF));
    end
`endif

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
